fir_interp_serial: RTL and testbench
====================================

Name: fir_interp_serial

Overview:
- Upsample-by-L polyphase interpolation low-pass filter for the 12-bit unsigned sample path.
- Consumes one input sample per valid/ready handshake and produces L filtered output samples per input.
- Uses a single time-multiplexed multiplier that walks the TAPS/L coefficients of each phase.
- Sits in front of the DAC/upsampling side of the design, as the rate-raising counterpart of the parallel decimation-side filter.

Parameters:
- L, 4, interpolation factor; TAPS must be a multiple of L.
- TAPS, 32, prototype filter length.
- DW, 12, input/output sample width (unsigned).
- AW, 28, signed accumulator width.

Ports:
- Clk  input  1  rising-edge clock.
- Hlt_n  input  1  asynchronous active-low reset.
- Din  input  DW  unsigned input sample.
- In_valid  input  1  Din valid.
- In_ready  output  1  block can accept a sample.
- Dout  output  DW  unsigned interpolated sample.
- Out_valid  output  1  Dout valid.
- Out_ready  input  1  downstream accepts Dout.
- Phase  output  log2(L)  polyphase index of the current Dout.

Behaviour:
- Coefficients: fixed signed 12-bit ROM h[0..31] = -3,0,1,4,10,19,31,46,64,83,103,123,141,156,167,173, then the same 16 values mirrored.
- Phase p uses h[p+L*j], j=0..TAPS/L-1. Per-phase coefficient sums: 558, 560, 560, 558.
- History: TAPS/L-deep register x[0..7]; x[0] is the newest sample.
  - On input handshake (In_valid && In_ready), history shifts and x[0] <= Din zero-extended.
- FSM states: IDLE, MAC, OUT.
  - IDLE: In_ready=1. On handshake: go to MAC, phase=0, tap index j=0, acc=0.
  - MAC: one product per cycle, acc += $signed(x[j]) * h[phase+L*j], j increments; In_ready=0.
    - On the cycle with j=TAPS/L-1: Dout <= sat(final acc), Out_valid <= 1, go to OUT.
  - OUT: Dout, Phase and Out_valid held stable while Out_ready=0.
    - On Out_valid && Out_ready: Out_valid <= 0.
    - If phase<L-1: phase++, acc=0, j=0, go to MAC.
    - Else go to IDLE.
- Output scaling: Dout = acc >>> 9 (arithmetic), then saturated to [0, 4095].
  - Negative results clamp to 0; results >4095 clamp to 4095.
  - acc is never truncated before the shift.
- Timing:
  - Out_valid rises 8 cycles after the input-handshake edge.
  - With Out_ready tied high, one output every 9 cycles; 36 cycles per input when L=4.
  - In_ready returns high 1 cycle after the last phase's output handshake.
- In_valid while In_ready=0 is ignored: sample not captured, no state change.
- Out_ready while Out_valid=0 has no effect.
- Reset (Hlt_n low, any time, including mid-MAC or mid-OUT):
  - State=IDLE, history=0, acc=0, phase=0, j=0.
  - Dout=0, Out_valid=0, Phase=0, In_ready=0 while reset is asserted, 1 after release.
  - No partial output is emitted after reset release.
- Arithmetic: 12-bit unsigned sample × 12-bit signed coefficient → 25-bit signed product, accumulated in AW bits; no overflow is possible at defaults.

Test Plan:
- Reset then idle: hold Hlt_n low → Dout=0, Out_valid=0, Phase=0. Release → In_ready=1 next cycle, no Out_valid without input.
- Impulse response, Out_ready=1: feed 2048 then seven zeros → 32 outputs equal to 4*h[k] clamped, i.e. 0,0,4,16,40,76,124,184,256,…,692,692,…,16,4,0,0. Phase cycles 0,1,2,3.
- DC steady state: feed 2048 continuously for ≥8 inputs → Dout repeats 2232,2240,2240,2232.
- Saturation: constant 4095 → steady-state Dout=4095 on every phase (raw value 4478 clamped). Leading -3 taps on the impulse edge clamp to 0, never wrap.
- Backpressure: Out_ready low for 20 cycles mid-phase 2 → Dout/Phase/Out_valid stable; In_ready stays 0; In_valid pulses ignored; sequence resumes unchanged when released.
- Reset mid-operation: assert Hlt_n low during MAC of phase 1 → outputs clear immediately. After release, a fresh impulse 2048 reproduces the impulse sequence from phase 0, with no stale history.

Source files
------------

// File: rtl/fir_interp_serial_if.sv
// Sample stream bundle for the serial interpolation filter: one input
// stream (Din/In_valid/In_ready) and one output stream (Dout/Out_valid/
// Out_ready) with the polyphase index of the sample currently on Dout.
//
// Handshake: a transfer happens on a rising clock edge where valid and
// ready are both high. A source holds data and valid stable until that
// edge; ready may change freely and has no effect while valid is low.
interface fir_interp_serial_if #(
    parameter int DW = 12,
    parameter int LW = 2
);
    logic [DW-1:0] Din;
    logic          In_valid;
    logic          In_ready;
    logic [DW-1:0] Dout;
    logic          Out_valid;
    logic          Out_ready;
    logic [LW-1:0] Phase;

    // Filter side: consumes input samples, produces interpolated samples.
    modport slave (
        input  Din, In_valid, Out_ready,
        output In_ready, Dout, Out_valid, Phase
    );

    // Environment side: supplies samples and accepts the filtered stream.
    modport master (
        output Din, In_valid, Out_ready,
        input  In_ready, Dout, Out_valid, Phase
    );
endinterface

// File: rtl/fir_interp_serial.sv
// Upsample-by-L polyphase interpolation low-pass filter. Each accepted
// sample is pushed into an 8-deep history; then, for every phase p, one
// multiplier walks the taps h[p+L*j] over the history, and the scaled,
// clamped result is presented on Dout before the next phase starts.
module fir_interp_serial #(
    parameter int L    = 4,
    parameter int TAPS = 32,
    parameter int DW   = 12,
    parameter int AW   = 28
) (
    input  logic                 Clk,
    input  logic                 Hlt_n,
    fir_interp_serial_if.slave   bus,
    output logic [1:0]           dbg_state_o
);
    localparam int NT    = TAPS / L;
    localparam int JW    = (NT > 1) ? $clog2(NT) : 1;
    localparam int LW    = (L > 1) ? $clog2(L) : 1;
    localparam int IW    = $clog2(TAPS);
    localparam int CW    = 12;
    localparam int PW    = DW + 1 + CW;
    localparam int SHIFT = 9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                state_q;
    logic [DW-1:0]         hist_q [NT];
    logic signed [AW-1:0]  acc_q;
    logic [LW-1:0]         phase_q;
    logic [JW-1:0]         j_q;
    logic [DW-1:0]         dout_q;
    logic                  out_valid_q;
    logic                  in_ready_q;

    logic [IW-1:0]         idx;
    logic signed [DW:0]    sample_s;
    logic signed [CW-1:0]  coef;
    logic signed [PW-1:0]  prod;
    logic signed [AW-1:0]  acc_d;
    logic signed [AW-1:0]  shifted;
    logic [DW-1:0]         dout_d;

    // Symmetric prototype: the upper half mirrors the lower half, so only
    // 16 distinct values are stored and index k>=16 maps to 31-k.
    function automatic logic signed [CW-1:0] coef_rom(input logic [IW-1:0] k);
        logic [3:0] m;
        m = k[IW-1] ? ~k[3:0] : k[3:0];
        case (m)
            4'd0:    coef_rom = -12'sd3;
            4'd1:    coef_rom = 12'sd0;
            4'd2:    coef_rom = 12'sd1;
            4'd3:    coef_rom = 12'sd4;
            4'd4:    coef_rom = 12'sd10;
            4'd5:    coef_rom = 12'sd19;
            4'd6:    coef_rom = 12'sd31;
            4'd7:    coef_rom = 12'sd46;
            4'd8:    coef_rom = 12'sd64;
            4'd9:    coef_rom = 12'sd83;
            4'd10:   coef_rom = 12'sd103;
            4'd11:   coef_rom = 12'sd123;
            4'd12:   coef_rom = 12'sd141;
            4'd13:   coef_rom = 12'sd156;
            4'd14:   coef_rom = 12'sd167;
            default: coef_rom = 12'sd173;
        endcase
    endfunction

    // One multiply-accumulate step plus the scaled, clamped candidate output.
    always_comb begin
        idx      = IW'(phase_q) + IW'(L) * IW'(j_q);
        sample_s = $signed({1'b0, hist_q[j_q]});
        coef     = coef_rom(idx);
        prod     = PW'(sample_s) * PW'(coef);
        acc_d    = acc_q + AW'(prod);
        shifted  = acc_d >>> SHIFT;
        if (shifted[AW-1]) begin
            dout_d = '0;
        end else if (|shifted[AW-2:DW]) begin
            dout_d = '1;
        end else begin
            dout_d = shifted[DW-1:0];
        end
    end

    // Control FSM with registered handshake outputs, history and accumulator.
    always_ff @(posedge Clk or negedge Hlt_n) begin
        if (!Hlt_n) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < NT; i++) hist_q[i] <= '0;
            acc_q       <= '0;
            phase_q     <= '0;
            j_q         <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.In_valid && in_ready_q) begin
                        for (int i = NT - 1; i > 0; i--) hist_q[i] <= hist_q[i-1];
                        hist_q[0]  <= bus.Din;
                        in_ready_q <= 1'b0;
                        phase_q    <= '0;
                        j_q        <= '0;
                        acc_q      <= '0;
                        state_q    <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_d;
                    j_q   <= j_q + 1'b1;
                    if (j_q == JW'(NT - 1)) begin
                        dout_q      <= dout_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (bus.Out_ready) begin
                        out_valid_q <= 1'b0;
                        if (phase_q != LW'(L - 1)) begin
                            phase_q <= phase_q + 1'b1;
                            acc_q   <= '0;
                            j_q     <= '0;
                            state_q <= S_MAC;
                        end else begin
                            in_ready_q <= 1'b1;
                            state_q    <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.In_ready  = in_ready_q;
    assign bus.Dout      = dout_q;
    assign bus.Out_valid = out_valid_q;
    assign bus.Phase     = phase_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_fir_interp_serial.sv
// Bench for fir_interp_serial: directed steps with random samples and
// random backpressure, checked against a direct polyphase convolution model.
module tb_fir_interp_serial;
  logic       Clk;
  logic       Hlt_n;
  logic [1:0] dbg_state;
  logic       rand_bp;

  int checks = 0;
  int errors = 0;

  logic [13:0] exp_q[$];
  int          hist_m[$];
  int          h_lo [16] = '{-3, 0, 1, 4, 10, 19, 31, 46, 64, 83, 103, 123, 141, 156, 167, 173};

  fir_interp_serial_if #(.DW(12), .LW(2)) bus ();

  fir_interp_serial #(.L(4), .TAPS(32), .DW(12), .AW(28)) dut (
    .Clk         (Clk),
    .Hlt_n       (Hlt_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / watchdog
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // reference model: full convolution of the sample history with each phase
  function automatic int h_of(input int k);
    return (k < 16) ? h_lo[k] : h_lo[31 - k];
  endfunction

  function automatic logic [11:0] model_out(input int p);
    longint acc;
    longint y;
    acc = 0;
    for (int j = 0; j < 8; j++) begin
      if (j < hist_m.size()) acc += longint'(hist_m[j]) * longint'(h_of(p + 4 * j));
    end
    y = acc >>> 9;
    if (y < 0) return 12'd0;
    if (y > 4095) return 12'd4095;
    return y[11:0];
  endfunction

  task automatic model_push(input int d);
    logic [1:0] pp;
    hist_m.push_front(d);
    if (hist_m.size() > 8) void'(hist_m.pop_back());
    for (int p = 0; p < 4; p++) begin
      pp = p[1:0];
      exp_q.push_back({pp, model_out(p)});
    end
  endtask

  // scoreboard: compare every output transfer with the model's next value
  always @(negedge Clk) begin
    logic [13:0] e;
    if (Hlt_n && bus.Out_valid && bus.Out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("dout", 32'(bus.Dout), 32'(e[11:0]));
        check("phase", 32'(bus.Phase), 32'(e[13:12]));
      end
    end
  end

  // random backpressure when enabled
  always @(posedge Clk) begin
    if (rand_bp) begin
      #1;
      bus.Out_ready = 1'($urandom_range(0, 1));
    end
  end

  // driver tasks
  task automatic push_sample(input int d);
    int n;
    n = 0;
    while (!bus.In_ready && n < 400) begin
      @(posedge Clk); #1;
      n++;
    end
    if (n >= 400) begin
      check("in_ready_timeout", 32'd0, 32'd1);
    end else begin
      bus.Din      = 12'(d);
      bus.In_valid = 1'b1;
      @(posedge Clk); #1;
      bus.In_valid = 1'b0;
      model_push(d);
    end
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    while (!bus.Out_valid && n < 50) begin
      @(posedge Clk); #1;
      n++;
    end
  endtask

  task automatic wait_in_ready(output int n);
    n = 0;
    while (!bus.In_ready && n < 400) begin
      @(posedge Clk); #1;
      n++;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    wait_in_ready(n);
    check({tag, "_ready"}, 32'(bus.In_ready), 32'd1);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // directed sequence
  initial begin
    int lat1, lat2, n, bad, rdy_bad;
    logic [11:0] held_d;
    logic [1:0]  held_p;

    Hlt_n        = 1'b0;
    rand_bp      = 1'b0;
    bus.Din      = '0;
    bus.In_valid = 1'b0;
    bus.Out_ready = 1'b1;

    // reset then idle
    repeat (3) @(posedge Clk);
    #1;
    check("rst_dout", 32'(bus.Dout), 32'd0);
    check("rst_out_valid", 32'(bus.Out_valid), 32'd0);
    check("rst_phase", 32'(bus.Phase), 32'd0);
    check("rst_in_ready", 32'(bus.In_ready), 32'd0);
    Hlt_n = 1'b1;
    @(posedge Clk); #1;
    check("in_ready_after_release", 32'(bus.In_ready), 32'd1);
    bad = 0;
    repeat (6) begin
      @(posedge Clk); #1;
      if (bus.Out_valid) bad++;
    end
    check("idle_no_output", 32'(bad), 32'd0);

    // impulse response with timing
    push_sample(2048);
    wait_out_valid(lat1);
    check("first_out_latency", 32'(lat1), 32'd8);
    wait_in_ready(lat2);
    check("cycles_per_input", 32'(lat1 + lat2), 32'd36);
    for (int i = 0; i < 7; i++) push_sample(0);
    drain("impulse");

    // DC steady state
    for (int i = 0; i < 10; i++) push_sample(2048);
    drain("dc");

    // saturation
    for (int i = 0; i < 10; i++) push_sample(4095);
    drain("sat");

    // backpressure during phase 2
    push_sample(2048);
    n = 0;
    while (!(bus.Phase == 2'd2 && !bus.Out_valid) && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    check("reach_phase2", 32'(n < 100), 32'd1);
    bus.Out_ready = 1'b0;
    wait_out_valid(n);
    check("phase2_valid", 32'(bus.Out_valid), 32'd1);
    held_d  = bus.Dout;
    held_p  = bus.Phase;
    bad     = 0;
    rdy_bad = 0;
    for (int i = 0; i < 20; i++) begin
      bus.Din      = 12'($urandom_range(0, 4095));
      bus.In_valid = 1'($urandom_range(0, 1));
      @(posedge Clk); #1;
      if (bus.Dout !== held_d || bus.Phase !== held_p || bus.Out_valid !== 1'b1) bad++;
      if (bus.In_ready !== 1'b0) rdy_bad++;
    end
    bus.In_valid = 1'b0;
    check("bp_outputs_stable", 32'(bad), 32'd0);
    check("bp_in_ready_low", 32'(rdy_bad), 32'd0);
    check("bp_phase_held", 32'(held_p), 32'd2);
    bus.Out_ready = 1'b1;
    drain("bp");

    // random samples under random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 12; i++) push_sample(int'($urandom_range(0, 4095)));
    rand_bp = 1'b0;
    @(posedge Clk); #2;
    bus.Out_ready = 1'b1;
    drain("random");

    // reset in the middle of phase-1 accumulation
    push_sample(3000);
    n = 0;
    while (!(bus.Phase == 2'd1 && !bus.Out_valid) && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    check("reach_phase1", 32'(n < 100), 32'd1);
    #1;
    Hlt_n = 1'b0;
    #1;
    check("midrst_dout", 32'(bus.Dout), 32'd0);
    check("midrst_out_valid", 32'(bus.Out_valid), 32'd0);
    check("midrst_phase", 32'(bus.Phase), 32'd0);
    check("midrst_in_ready", 32'(bus.In_ready), 32'd0);
    exp_q.delete();
    hist_m.delete();
    repeat (3) @(posedge Clk);
    #1;
    Hlt_n = 1'b1;
    bad = 0;
    repeat (10) begin
      @(posedge Clk); #1;
      if (bus.Out_valid) bad++;
    end
    check("no_partial_after_reset", 32'(bad), 32'd0);
    push_sample(2048);
    for (int i = 0; i < 7; i++) push_sample(0);
    drain("post_reset_impulse");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
